// File: rtl/lossy_fifo_pkg.sv
// Shared types and helpers for the lossy FIFO: full-policy encoding and
// a wrap-around pointer increment.
package lossy_fifo_pkg;

  // Policy applied when a write arrives while the FIFO is full and no pop
  // frees a slot in the same cycle.
  typedef enum logic {
    FIFO_OVERWRITE = 1'b0,  // evict the oldest entry, keep the new one
    FIFO_DROP_NEW  = 1'b1   // keep the stored entries, discard the new one
  } fifo_mode_e;

  // Increment a ring pointer, wrapping from depth-1 back to 0.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/lossy_fifo.sv
// Single-clock FIFO for producers that cannot be stalled. A write while
// full either evicts the oldest entry or discards the new data, depending
// on MODE; every lost entry raises a one-cycle drop pulse and bumps a
// saturating loss counter. dout is show-ahead (head entry, no read latency).
module lossy_fifo
  import lossy_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int MODE       = 0,
  parameter int DROP_W     = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       wr,
  input  logic                       rd,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam bit OVERWRITE = (MODE == int'(FIFO_OVERWRITE));

  // Reject configurations the pointer arithmetic cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("lossy_fifo: DEPTH must be a power of two and at least 2");
  end
  if ((MODE != int'(FIFO_OVERWRITE)) && (MODE != int'(FIFO_DROP_NEW))) begin : g_bad_mode
    $error("lossy_fifo: MODE must be 0 (overwrite) or 1 (drop new)");
  end

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  full_reg, full_next;
  logic                  empty_reg, empty_next;
  logic                  drop_reg, drop_next;
  logic [DROP_W-1:0]     drop_cnt_reg, drop_cnt_next;

  logic eff_rd;
  logic overflow;
  logic do_write;
  logic do_pop;

  // Next-state: decide write/pop for this cycle, then derive pointers,
  // occupancy, flags and loss accounting from that decision.
  always_comb begin
    eff_rd        = rd & ~empty_reg;
    // A write is lossy only when full and nothing leaves in the same cycle.
    overflow      = wr & full_reg & ~eff_rd;
    do_write      = wr & (~overflow | OVERWRITE);
    // In overwrite mode the eviction is just a pop of the oldest entry.
    do_pop        = eff_rd | (overflow & OVERWRITE);

    wr_ptr_next   = do_write ? PTR_W'(ptr_inc(32'(wr_ptr_reg), DEPTH)) : wr_ptr_reg;
    rd_ptr_next   = do_pop   ? PTR_W'(ptr_inc(32'(rd_ptr_reg), DEPTH)) : rd_ptr_reg;
    count_next    = count_reg + CNT_W'(do_write) - CNT_W'(do_pop);
    full_next     = (count_next == CNT_W'(DEPTH));
    empty_next    = (count_next == '0);

    drop_next     = overflow;
    drop_cnt_next = drop_cnt_reg;
    if (overflow && (drop_cnt_reg != '1)) begin
      drop_cnt_next = drop_cnt_reg + DROP_W'(1);
    end
  end

  // State register and storage; reset clears content so dout reads 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      drop_reg     <= 1'b0;
      drop_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      full_reg     <= full_next;
      empty_reg    <= empty_next;
      drop_reg     <= drop_next;
      drop_cnt_reg <= drop_cnt_next;
      if (do_write) begin
        mem_reg[wr_ptr_reg] <= din;
      end
    end
  end

  assign dout     = mem_reg[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;
  assign drop     = drop_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
